// File: rtl/lzs_pkg.sv
// Shared constants and FSM state encoding for the LZS stream aligner.
package lzs_pkg;
  localparam int WORD_WIDTH    = 16;
  localparam int BUF_WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/lzs_stream_shift.sv
// Combinational next-value logic for the left-aligned bit buffer:
// optional consume (shift left, zero fill) followed by optional word merge.
module lzs_stream_shift
  import lzs_pkg::*;
#(
  parameter int BUF_WIDTH = BUF_WIDTH_DEF
) (
  input  logic [BUF_WIDTH-1:0]  buf_q,
  input  logic [6:0]            left_q,
  input  logic                  shift_en,
  input  logic [3:0]            shift_width,
  input  logic                  merge_en,
  input  logic [WORD_WIDTH-1:0] word,
  output logic [BUF_WIDTH-1:0]  buf_d,
  output logic [6:0]            left_d
);

  logic [BUF_WIDTH-1:0] buf_s;
  logic [6:0]           left_s;
  logic [6:0]           width_ext;

  always_comb begin
    width_ext = {3'b000, shift_width};
    buf_s     = buf_q;
    left_s    = left_q;
    if (shift_en) begin
      buf_s  = buf_q << shift_width;
      left_s = (left_q > width_ext) ? (left_q - width_ext) : '0;
    end

    // Merge lands the word MSB directly after the last bit surviving the shift.
    buf_d  = buf_s;
    left_d = left_s;
    if (merge_en) begin
      buf_d  = buf_s | ({word, {(BUF_WIDTH-WORD_WIDTH){1'b0}}} >> left_s);
      left_d = left_s + 7'd16;
    end
  end

endmodule

// File: rtl/lzs_stream_align.sv
// Aligns 16-bit compressed words into an MSB-first look-ahead window for an LZS decoder.
// Optional protocol checking is enabled by defining LZS_ALIGN_CHECK_EN.
module lzs_stream_align
  import lzs_pkg::*;
#(
  parameter int IN_WIDTH  = 13,
  parameter int BUF_WIDTH = BUF_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           word_data,
  input  logic                  word_valid,
  input  logic                  word_last,
  output logic                  word_ready,
  output logic                  stream_valid,
  output logic [IN_WIDTH-1:0]   stream_data,
  output logic                  stream_empty,
  input  logic                  stream_ack,
  input  logic [3:0]            stream_width,
  output logic                  err
);

  localparam logic [6:0] IN_W7     = 7'(IN_WIDTH);
  localparam logic [6:0] READY_MAX = 7'(BUF_WIDTH - WORD_WIDTH);

  logic [BUF_WIDTH-1:0] bit_buf;
  logic [BUF_WIDTH-1:0] bit_buf_d;
  logic [6:0]           left;
  logic [6:0]           left_d;
  state_t               state;
  state_t               state_d;
  logic                 started;
  logic                 accept;
  logic                 ack;

  assign accept = word_valid & word_ready;
  assign ack    = stream_ack & stream_valid;

  lzs_stream_shift #(
    .BUF_WIDTH(BUF_WIDTH)
  ) u_shift (
    .buf_q      (bit_buf),
    .left_q     (left),
    .shift_en   (ack),
    .shift_width(stream_width),
    .merge_en   (accept),
    .word       (word_data),
    .buf_d      (bit_buf_d),
    .left_d     (left_d)
  );

  // Transitions look at the post-edge fill level so the window is valid
  // on the same edge that makes enough bits available.
  always_comb begin
    state_d = state;
    case (state)
      FILL: begin
        if (accept && word_last)  state_d = DRAIN;
        else if (left_d >= IN_W7) state_d = RUN;
      end
      RUN: begin
        if (accept && word_last) state_d = DRAIN;
        else if (left_d < IN_W7) state_d = FILL;
      end
      DRAIN: begin
        if (left_d == '0) state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_buf <= '0;
      left    <= '0;
      state   <= FILL;
      started <= 1'b0;
    end else begin
      bit_buf <= bit_buf_d;
      left    <= left_d;
      state   <= state_d;
      started <= 1'b1;
    end
  end

  assign word_ready   = started && (left <= READY_MAX) && ((state == FILL) || (state == RUN));
  assign stream_valid = (state == RUN) || ((state == DRAIN) && (left != '0));
  assign stream_data  = bit_buf[BUF_WIDTH-1 -: IN_WIDTH];
  assign stream_empty = (state == DONE);

`ifdef LZS_ALIGN_CHECK_EN
  logic err_q;
  logic err_hit;

  always_comb begin
    err_hit = 1'b0;
    if (ack && ({3'b000, stream_width} > IN_W7))                     err_hit = 1'b1;
    if (ack && (state == DRAIN) && ({3'b000, stream_width} > left))  err_hit = 1'b1;
    if (word_valid && ((state == DRAIN) || (state == DONE)))         err_hit = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_q <= 1'b0;
    else if (err_hit) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lzs_stream_align.sv
// Directed self-checking bench for lzs_stream_align (IN_WIDTH=13, BUF_WIDTH=64).
module tb_lzs_stream_align;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] word_data;
  logic        word_valid;
  logic        word_last;
  logic        word_ready;
  logic        stream_valid;
  logic [12:0] stream_data;
  logic        stream_empty;
  logic        stream_ack;
  logic [3:0]  stream_width;
  logic        err;

  int checks   = 0;
  int failures = 0;

  lzs_stream_align #(
    .IN_WIDTH (13),
    .BUF_WIDTH(64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_last   (word_last),
    .word_ready  (word_ready),
    .stream_valid(stream_valid),
    .stream_data (stream_data),
    .stream_empty(stream_empty),
    .stream_ack  (stream_ack),
    .stream_width(stream_width),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  bit          model_q[$];
  logic [15:0] words[64];
  logic [12:0] win;
  logic [15:0] mid;
  int          idx;
  int          stalls;
  bit          acc;
  bit          ak;
  bit          seen_valid;

`ifdef LZS_ALIGN_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  initial begin
    rst = 1'b1; word_data = '0; word_valid = 1'b0; word_last = 1'b0;
    stream_ack = 1'b0; stream_width = '0;
    step(); step();

    // reset state
    chk("rst_ready", {63'b0, word_ready}, 64'd0);
    chk("rst_valid", {63'b0, stream_valid}, 64'd0);
    chk("rst_data",  {51'b0, stream_data}, 64'd0);
    chk("rst_empty", {63'b0, stream_empty}, 64'd0);
    chk("rst_err",   {63'b0, err}, 64'd0);
    #2 rst = 1'b0;
    chk("rel_ready_low", {63'b0, word_ready}, 64'd0);
    step();
    chk("rel_ready_high", {63'b0, word_ready}, 64'd1);

    // startup: two words, no ack
    word_valid = 1'b1; word_data = 16'hA5C3;
    step();
    chk("start_valid", {63'b0, stream_valid}, 64'd1);
    chk("start_data1", {51'b0, stream_data}, 64'h14B8);
    word_data = 16'h0F0F;
    step();
    word_valid = 1'b0;
    chk("start_data2", {51'b0, stream_data}, 64'h14B8);
    chk("start_left",  {57'b0, dut.left}, 64'd32);

    // simultaneous ack and accept at left=48
    word_valid = 1'b1; word_data = 16'h1234;
    step();
    chk("sim_left48",  {57'b0, dut.left}, 64'd48);
    chk("sim_ready48", {63'b0, word_ready}, 64'd1);
    word_data = 16'hBEEF; stream_ack = 1'b1; stream_width = 4'd13;
    step();
    word_valid = 1'b0; stream_ack = 1'b0;
    chk("sim_left51", {57'b0, dut.left}, 64'd51);
    mid = dut.bit_buf[28:13];
    chk("sim_word_pos", {48'b0, mid}, 64'hBEEF);
    chk("sim_data",     {51'b0, stream_data}, 64'h0C3C);
    chk("sim_ready51",  {63'b0, word_ready}, 64'd0);

    // bring left to 40 then reset mid-stream
    stream_ack = 1'b1; stream_width = 4'd11;
    step();
    stream_ack = 1'b0;
    chk("mid_left40", {57'b0, dut.left}, 64'd40);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {63'b0, stream_valid}, 64'd0);
    chk("mid_rst_data",  {51'b0, stream_data}, 64'd0);
    chk("mid_rst_ready", {63'b0, word_ready}, 64'd0);
    chk("mid_rst_empty", {63'b0, stream_empty}, 64'd0);
    chk("mid_rst_left",  {57'b0, dut.left}, 64'd0);
    step();
    #2 rst = 1'b0;
    step();

    // continuous consumption, width 9 every cycle over 64 random words
    foreach (words[i]) words[i] = 16'($urandom);
    idx = 0; stalls = 0; seen_valid = 1'b0;
    word_valid = 1'b1; word_data = words[0];
    stream_ack = 1'b1; stream_width = 4'd9;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (idx >= 64 && model_q.size() < 13) break;
      if (stream_valid) begin
        seen_valid = 1'b1;
        for (int b = 0; b < 13; b++) win[12-b] = (b < model_q.size()) ? model_q[b] : 1'b0;
        chk("cont_window", {51'b0, stream_data}, {51'b0, win});
      end else if (seen_valid && idx < 64) begin
        stalls++;
      end
      acc = word_valid && word_ready;
      ak  = stream_valid;
      step();
      if (ak) for (int b = 0; b < 9; b++) if (model_q.size() > 0) void'(model_q.pop_front());
      if (acc) begin
        for (int b = 15; b >= 0; b--) model_q.push_back(words[idx][b]);
        idx++;
      end
      word_valid = (idx < 64);
      word_data  = (idx < 64) ? words[idx] : 16'h0000;
    end
    stream_ack = 1'b0; word_valid = 1'b0;
    chk("cont_all_words", 64'(idx), 64'd64);
    chk("cont_no_stall",  64'(stalls), 64'd0);
    chk("cont_tail_left", {57'b0, dut.left}, 64'(model_q.size()));
    chk("cont_err",       {63'b0, err}, 64'd0);

    // drain: last word 8001 at left=0
    #2 rst = 1'b1;
    step();
    #2 rst = 1'b0;
    step();
    word_valid = 1'b1; word_last = 1'b1; word_data = 16'h8001;
    step();
    word_valid = 1'b0; word_last = 1'b0;
    chk("drain_data0",  {51'b0, stream_data}, 64'h1000);
    chk("drain_valid0", {63'b0, stream_valid}, 64'd1);
    chk("drain_ready0", {63'b0, word_ready}, 64'd0);
    stream_ack = 1'b1; stream_width = 4'd13;
    step();
    chk("drain_data1",  {51'b0, stream_data}, 64'h0400);
    chk("drain_left1",  {57'b0, dut.left}, 64'd3);
    chk("drain_empty1", {63'b0, stream_empty}, 64'd0);
    stream_width = 4'd3;
    step();
    stream_ack = 1'b0;
    chk("drain_empty",  {63'b0, stream_empty}, 64'd1);
    chk("drain_valid",  {63'b0, stream_valid}, 64'd0);
    chk("drain_ready",  {63'b0, word_ready}, 64'd0);
    chk("drain_err",    {63'b0, err}, 64'd0);

    // protocol check: ack width 14 while streaming
    #2 rst = 1'b1;
    step();
    #2 rst = 1'b0;
    step();
    word_valid = 1'b1; word_data = 16'hFFFF;
    step();
    word_valid = 1'b0;
    chk("chk_pre_err", {63'b0, err}, 64'd0);
    stream_ack = 1'b1; stream_width = 4'd14;
    step();
    stream_ack = 1'b0; stream_width = 4'd0;
    chk("chk_err_set", {63'b0, err}, {63'b0, ERR_EXP});
    step(); step();
    chk("chk_err_held", {63'b0, err}, {63'b0, ERR_EXP});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
